// File: rtl/upsample_2x_if.sv
// Handshake bundle for the 2x2 upsampler: valid/ready input stream in,
// valid/ready output stream plus end-of-frame pulse out.
interface upsample_2x_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_out;
    logic                  done;

    modport slave (
        input  valid_in, data_in, ready_out,
        output ready_in, data_out, valid_out, done
    );

    modport master (
        output valid_in, data_in, ready_out,
        input  ready_in, data_out, valid_out, done
    );
endinterface

// File: rtl/upsample_2x.sv
// Streaming 2x2 upsampler: each input pixel becomes a 2x2 output block.
// Define UPSAMPLE_ZERO_FILL_EN for max-unpooling zero fill (no line buffer).
module upsample_2x #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 14,
    parameter int HEIGHT     = 14
) (
    input  logic          clk,
    input  logic          reset,
    upsample_2x_if.slave  bus
);
    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    typedef enum logic [0:0] {
        S_PASS   = 1'b0,
        S_REPLAY = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [COL_W-1:0]      col_r;
    logic [COL_W-1:0]      col_nxt_s;
    logic [ROW_W-1:0]      row_r;
    logic [ROW_W-1:0]      row_nxt_s;
    logic                  dup_r;
    logic                  valid_out_r;
    logic [DATA_WIDTH-1:0] data_out_r;

    logic fire_s;
    logic load_ok_s;
    logic accept_s;
    logic replay_load_s;
    logic done_s;

    // The position advances only when the second copy of a pixel is consumed;
    // it then names the pixel to load next, so a load can overlap that fire.
    assign fire_s    = valid_out_r & bus.ready_out;
    assign load_ok_s = ~dup_r & (~valid_out_r | bus.ready_out);

    // Next position (state/column/row) after the current output beat
    always_comb begin
        state_nxt_s = state_r;
        col_nxt_s   = col_r;
        row_nxt_s   = row_r;
        if (fire_s && !dup_r) begin
            case (state_r)
                S_PASS: begin
                    if (col_r == COL_LAST) begin
                        state_nxt_s = S_REPLAY;
                        col_nxt_s   = '0;
                    end else begin
                        col_nxt_s = col_r + COL_W'(1);
                    end
                end
                S_REPLAY: begin
                    if (col_r == COL_LAST) begin
                        state_nxt_s = S_PASS;
                        col_nxt_s   = '0;
                        if (row_r == ROW_LAST) begin
                            row_nxt_s = '0;
                        end else begin
                            row_nxt_s = row_r + ROW_W'(1);
                        end
                    end else begin
                        col_nxt_s = col_r + COL_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = S_PASS;
                    col_nxt_s   = '0;
                    row_nxt_s   = '0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Load source selection and the end-of-frame pulse
    always_comb begin
        accept_s      = 1'b0;
        replay_load_s = 1'b0;
        bus.ready_in  = 1'b0;
        if (!reset && load_ok_s) begin
            if (state_nxt_s == S_PASS) begin
                bus.ready_in = 1'b1;
                accept_s     = bus.valid_in;
            end else begin
                replay_load_s = 1'b1;
            end
        end else begin
            bus.ready_in = 1'b0;
        end
        done_s = ~reset & fire_s & ~dup_r & (state_r == S_REPLAY)
                 & (col_r == COL_LAST) & (row_r == ROW_LAST);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_PASS;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Column and row counters
    always_ff @(posedge clk) begin
        if (reset) begin
            col_r <= '0;
            row_r <= '0;
        end else begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
        end
    end

`ifdef UPSAMPLE_ZERO_FILL_EN
    // Output register: only the first copy of a pass beat carries the pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out_r <= 1'b0;
            data_out_r  <= '0;
            dup_r       <= 1'b0;
        end else if (accept_s) begin
            data_out_r  <= bus.data_in;
            valid_out_r <= 1'b1;
            dup_r       <= 1'b1;
        end else if (replay_load_s) begin
            data_out_r  <= '0;
            valid_out_r <= 1'b1;
            dup_r       <= 1'b1;
        end else if (fire_s && dup_r) begin
            data_out_r <= '0;
            dup_r      <= 1'b0;
        end else if (fire_s) begin
            valid_out_r <= 1'b0;
        end
    end
`else
    logic [DATA_WIDTH-1:0] line_buf_r [WIDTH];

    // Line buffer captures each accepted pixel for the replayed row
    always_ff @(posedge clk) begin
        if (accept_s) begin
            line_buf_r[col_nxt_s] <= bus.data_in;
        end
    end

    // Output register: second copy keeps data_out, replay reads the buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out_r <= 1'b0;
            data_out_r  <= '0;
            dup_r       <= 1'b0;
        end else if (accept_s) begin
            data_out_r  <= bus.data_in;
            valid_out_r <= 1'b1;
            dup_r       <= 1'b1;
        end else if (replay_load_s) begin
            data_out_r  <= line_buf_r[col_nxt_s];
            valid_out_r <= 1'b1;
            dup_r       <= 1'b1;
        end else if (fire_s && dup_r) begin
            dup_r <= 1'b0;
        end else if (fire_s) begin
            valid_out_r <= 1'b0;
        end
    end
`endif

    assign bus.data_out  = data_out_r;
    assign bus.valid_out = valid_out_r;
    assign bus.done      = done_s;
endmodule
